// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a single-ported word memory.
// Byte/half loads are extracted and extended; byte/half stores use read-modify-write.
`timescale 1ns/1ps
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        mem_enable_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic             next_err;
    logic             err_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      req_addr;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic             req_write;
    logic [31:0]      mem_data_q;
    logic             req_any;
    logic             req_illegal;
    logic             accept;
    logic             timeout;

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                                input logic [1:0] off, input logic [1:0] size);
        logic [31:0] r;
        r = word;
        if (size == 2'b00) begin
            case (off)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end else if (size == 2'b01) begin
            if (off[1]) r[31:16] = wd[15:0];
            else        r[15:0]  = wd[15:0];
        end else begin
            r = wd;
        end
        return r;
    endfunction

    assign req_any     = MemRead_i | MemWrite_i;
    assign req_illegal = (MemRead_i & MemWrite_i) || (size_i == 2'b11) ||
                         ((size_i == 2'b01) && addr_i[0]) ||
                         ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));
    assign accept      = (state == IDLE) && req_any && !req_illegal;
    assign timeout     = (wait_cnt == CNT_LAST) && !mem_ack_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= next_state;
            err_q <= next_err;
        end
    end

    always_comb begin
        next_state = state;
        next_err   = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    if (req_illegal) begin
                        next_state = DONE;
                        next_err   = 1'b1;
                    end else if (MemWrite_i && (size_i == 2'b10)) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            RD: begin
                if (mem_ack_i) begin
                    next_state = req_write ? WR : DONE;
                end else if (timeout) begin
                    next_state = DONE;
                    next_err   = 1'b1;
                end
            end
            WR: begin
                if (mem_ack_i) begin
                    next_state = DONE;
                end else if (timeout) begin
                    next_state = DONE;
                    next_err   = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_enable_o = (state == RD) || (state == WR);
        mem_write_o  = (state == WR);
        stall_o      = ((state == IDLE) && req_any) || (state == RD) || (state == WR);
        err_o        = err_q;
        mem_addr_o   = {req_addr[31:2], 2'b00};
        mem_data_o   = mem_data_q;
    end

    // Wait counter restarts on every state change, so RD->WR of a read-modify-write gets a fresh budget.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wait_cnt <= '0;
        end else if (state != next_state) begin
            wait_cnt <= '0;
        end else if (((state == RD) || (state == WR)) && !mem_ack_i) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            req_addr     <= addr_i;
            req_size     <= size_i;
            req_unsigned <= unsigned_i;
            req_write    <= MemWrite_i;
            mem_data_q   <= write_data_i;
        end else if ((state == RD) && mem_ack_i && req_write) begin
            mem_data_q <= store_merge(mem_data_i, mem_data_q, req_addr[1:0], req_size);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            read_data_o <= '0;
        end else if ((state == RD) && mem_ack_i && !req_write) begin
            read_data_o <= load_extend(mem_data_i, req_addr[1:0], req_size, req_unsigned);
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, corner sequences, and random traffic
// checked against an arithmetic model of loads, stores, alignment and timeouts.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int T = 64;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i, unsigned_i, mem_ack_i;
    logic [31:0] addr_i, write_data_i, mem_data_i;
    logic [1:0]  size_i;
    logic [31:0] read_data_o, mem_addr_o, mem_data_o;
    logic        stall_o, err_o, mem_enable_o, mem_write_o;

    mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .size_i(size_i), .unsigned_i(unsigned_i), .write_data_i(write_data_i),
        .read_data_o(read_data_o), .stall_o(stall_o), .err_o(err_o), .mem_enable_o(mem_enable_o),
        .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stall;
        int          rcnt;
        int          wcnt;
        logic        addr_ok;
    } obs_t;

    typedef struct {
        bit          rd, wr;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] wd;
        int          lr, lw;
        logic [31:0] pre, exp_rdata;
        bit          exp_err;
        logic [31:0] exp_mem;
        int          exp_stall, exp_rcnt, exp_wcnt;
    } vec_t;

    logic [31:0] dut_mem [64];
    logic [31:0] ref_mem [64];
    vec_t        vecs [15];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Plays the pipeline (holds the request while stalled) and the memory (acks after lr/lw wait cycles).
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [1:0] size,
                           input bit uns, input logic [31:0] wd, input int lr, input int lw, output obs_t o);
        int idx, phase_n;
        bit prev_en, prev_wr, done;
        idx = int'(addr[7:2]);
        o.stall = 0; o.rcnt = 0; o.wcnt = 0; o.addr_ok = 1'b1; o.err = 1'b0; o.rdata = 32'h0;
        MemRead_i = rd; MemWrite_i = wr; addr_i = addr; size_i = size; unsigned_i = uns;
        write_data_i = wd; mem_ack_i = 1'b0;
        prev_en = 1'b0; prev_wr = 1'b0; phase_n = 0; done = 1'b0;
        for (int g = 0; g < 400 && !done; g++) begin
            #1;
            if (!stall_o) begin
                done = 1'b1;
                o.err = err_o;
                o.rdata = read_data_o;
                MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
                chk("done_enable_low", 32'(mem_enable_o), 32'h0);
            end else begin
                o.stall++;
                if (mem_enable_o) begin
                    if (mem_addr_o !== {addr[31:2], 2'b00}) o.addr_ok = 1'b0;
                    if (!prev_en || (prev_wr != mem_write_o)) phase_n = 0;
                    if (mem_write_o) o.wcnt++; else o.rcnt++;
                    if (phase_n == (mem_write_o ? lw : lr)) begin
                        mem_ack_i = 1'b1;
                        if (mem_write_o) dut_mem[idx] = mem_data_o;
                        else mem_data_i = dut_mem[idx];
                    end else begin
                        mem_ack_i = 1'b0;
                        mem_data_i = $urandom;
                    end
                    phase_n++;
                end else begin
                    mem_ack_i = 1'b0;
                end
                prev_en = mem_enable_o;
                prev_wr = mem_write_o;
                @(posedge clk_i); #1;
            end
        end
        if (!done) begin
            chk("txn_cycle_bound", 32'h0, 32'h1);
            MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b0;
        end
        @(posedge clk_i); #2;
        chk("err_single_cycle", 32'(err_o), 32'h0);
        chk("idle_no_stall", 32'(stall_o), 32'h0);
    endtask

    function automatic int pick_lat();
        return ($urandom_range(0, 24) == 0) ? T + int'($urandom_range(0, 5)) : int'($urandom_range(0, 4));
    endfunction

    initial begin
        obs_t        o;
        logic [31:0] cur_rdata, w, v, mask, r32, merged;
        logic [1:0]  sz;
        bit          rd, wr, uns, illegal, rto, wto;
        int          lr, lw, idx, sh, e_r, e_w, e_st;

        //          rd    wr    addr     sz     uns   wd            lr   lw    pre           exp_rdata     err   exp_mem     st  r   w
        vecs[0]  = '{1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        2,   0,    32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4, 3, 0};
        vecs[1]  = '{1'b1, 1'b0, 32'h13, 2'd0, 1'b0, 32'h0,        0,   0,    32'h80112233, 32'hFFFFFF80, 1'b0, 32'h80112233, 2, 1, 0};
        vecs[2]  = '{1'b1, 1'b0, 32'h13, 2'd0, 1'b1, 32'h0,        0,   0,    32'h80112233, 32'h00000080, 1'b0, 32'h80112233, 2, 1, 0};
        vecs[3]  = '{1'b0, 1'b1, 32'h06, 2'd1, 1'b0, 32'hABCD,     1,   1,    32'h11223344, 32'h00000080, 1'b0, 32'hABCD3344, 5, 2, 2};
        vecs[4]  = '{1'b1, 1'b0, 32'h02, 2'd2, 1'b0, 32'h0,        0,   0,    32'h01020304, 32'h00000080, 1'b1, 32'h01020304, 1, 0, 0};
        vecs[5]  = '{1'b1, 1'b0, 32'h06, 2'd1, 1'b0, 32'h0,        0,   0,    32'hABCD3344, 32'hFFFFABCD, 1'b0, 32'hABCD3344, 2, 1, 0};
        vecs[6]  = '{1'b1, 1'b0, 32'h04, 2'd1, 1'b1, 32'h0,        3,   0,    32'h1234F00D, 32'h0000F00D, 1'b0, 32'h1234F00D, 5, 4, 0};
        vecs[7]  = '{1'b0, 1'b1, 32'h21, 2'd0, 1'b0, 32'h1234565A, 0,   2,    32'hFFFFFFFF, 32'h0000F00D, 1'b0, 32'hFFFF5AFF, 5, 1, 3};
        vecs[8]  = '{1'b0, 1'b1, 32'h30, 2'd2, 1'b0, 32'hCAFEF00D, 0,   3,    32'h00000000, 32'h0000F00D, 1'b0, 32'hCAFEF00D, 5, 0, 4};
        vecs[9]  = '{1'b1, 1'b1, 32'h10, 2'd2, 1'b0, 32'h5555AAAA, 0,   0,    32'h76543210, 32'h0000F00D, 1'b1, 32'h76543210, 1, 0, 0};
        vecs[10] = '{1'b1, 1'b0, 32'h10, 2'd3, 1'b0, 32'h0,        0,   0,    32'h76543210, 32'h0000F00D, 1'b1, 32'h76543210, 1, 0, 0};
        vecs[11] = '{1'b0, 1'b1, 32'h05, 2'd1, 1'b0, 32'h1111,     0,   0,    32'hAAAAAAAA, 32'h0000F00D, 1'b1, 32'hAAAAAAAA, 1, 0, 0};
        vecs[12] = '{1'b1, 1'b0, 32'h12, 2'd0, 1'b0, 32'h0,        1,   0,    32'h007F0000, 32'h0000007F, 1'b0, 32'h007F0000, 3, 2, 0};
        vecs[13] = '{1'b1, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0,        1000, 0,  32'h00000000, 32'h0000007F, 1'b1, 32'h00000000, 65, 64, 0};
        vecs[14] = '{1'b0, 1'b1, 32'h1E, 2'd1, 1'b0, 32'hBEEF,     0,   1000, 32'h01020304, 32'h0000007F, 1'b1, 32'h01020304, 66, 1, 64};

        for (int i = 0; i < 64; i++) dut_mem[i] = 32'h0;
        rst_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = 32'h0; size_i = 2'd0;
        unsigned_i = 1'b0; write_data_i = 32'h0; mem_data_i = 32'h0; mem_ack_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_read_data", read_data_o, 32'h0);
        chk("reset_err", 32'(err_o), 32'h0);
        chk("reset_enable", 32'(mem_enable_o), 32'h0);
        chk("reset_write", 32'(mem_write_o), 32'h0);
        chk("reset_stall", 32'(stall_o), 32'h0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        foreach (vecs[i]) begin
            idx = int'(vecs[i].addr[7:2]);
            dut_mem[idx] = vecs[i].pre;
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wd,
                    vecs[i].lr, vecs[i].lw, o);
            chk($sformatf("vec%0d_rdata", i), o.rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(o.err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_mem", i), dut_mem[idx], vecs[i].exp_mem);
            chk($sformatf("vec%0d_stall", i), o.stall, vecs[i].exp_stall);
            chk($sformatf("vec%0d_rd_cycles", i), o.rcnt, vecs[i].exp_rcnt);
            chk($sformatf("vec%0d_wr_cycles", i), o.wcnt, vecs[i].exp_wcnt);
            chk($sformatf("vec%0d_addr", i), 32'(o.addr_ok), 32'h1);
        end

        // Late ack after a timeout must be ignored.
        mem_ack_i = 1'b1; mem_data_i = 32'h12345678;
        @(posedge clk_i); #1;
        chk("late_ack_enable", 32'(mem_enable_o), 32'h0);
        chk("late_ack_rdata", read_data_o, 32'h0000007F);
        chk("late_ack_err", 32'(err_o), 32'h0);
        mem_ack_i = 1'b0;
        @(posedge clk_i); #1;

        // Reset lands on the read-ack edge of a byte store: the write must never appear.
        MemWrite_i = 1'b1; addr_i = 32'h08; size_i = 2'd0; write_data_i = 32'h99; unsigned_i = 1'b0;
        @(posedge clk_i); #1;
        chk("rmw_rd_enable", 32'(mem_enable_o), 32'h1);
        chk("rmw_rd_not_write", 32'(mem_write_o), 32'h0);
        mem_ack_i = 1'b1; mem_data_i = 32'h55667788; rst_i = 1'b0; MemWrite_i = 1'b0;
        @(posedge clk_i); #1;
        chk("rst_rmw_enable", 32'(mem_enable_o), 32'h0);
        chk("rst_rmw_write", 32'(mem_write_o), 32'h0);
        chk("rst_rmw_err", 32'(err_o), 32'h0);
        chk("rst_rmw_rdata", read_data_o, 32'h0);
        chk("rst_rmw_stall", 32'(stall_o), 32'h0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("post_rst_ack_enable", 32'(mem_enable_o), 32'h0);
        chk("post_rst_ack_write", 32'(mem_write_o), 32'h0);
        chk("post_rst_ack_rdata", read_data_o, 32'h0);
        mem_ack_i = 1'b0;
        @(posedge clk_i); #1;

        // Random traffic against the reference model.
        cur_rdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            dut_mem[i] = w;
            ref_mem[i] = w;
        end
        for (int n = 0; n < 150; n++) begin
            e_r = $urandom_range(0, 9);
            rd = (e_r < 5);
            wr = (e_r == 0) || (e_r >= 5);
            e_r = $urandom_range(0, 7);
            sz = (e_r == 7) ? 2'd3 : 2'(e_r % 3);
            r32 = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) r32[0] = 1'b0;
                if (sz == 2'd2) r32[1:0] = 2'b00;
            end
            uns = bit'($urandom_range(0, 1));
            w = $urandom;
            lr = pick_lat();
            lw = pick_lat();
            idx = int'(r32[7:2]);
            sh = 8 * int'(r32[1:0]);
            mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;

            illegal = (rd && wr) || (sz == 2'd3) || (sz == 2'd1 && r32[0]) ||
                      (sz == 2'd2 && r32[1:0] != 2'b00);
            rto = 1'b0; wto = 1'b0; e_r = 0; e_w = 0;
            if (!illegal) begin
                if (rd || sz != 2'd2) begin
                    rto = (lr >= T);
                    e_r = rto ? T : lr + 1;
                end
                if (wr && !rto) begin
                    wto = (lw >= T);
                    e_w = wto ? T : lw + 1;
                end
            end
            e_st = 1 + e_r + e_w;
            if (!illegal && rd && !rto) begin
                v = ref_mem[idx] >> sh;
                if (sz == 2'd0) begin
                    v = v & 32'hFF;
                    if (!uns && v[7]) v = v | 32'hFFFFFF00;
                end else if (sz == 2'd1) begin
                    v = v & 32'hFFFF;
                    if (!uns && v[15]) v = v | 32'hFFFF0000;
                end
                cur_rdata = v;
            end
            if (!illegal && wr && !rto && !wto) begin
                merged = (sz == 2'd2) ? w : ((ref_mem[idx] & ~(mask << sh)) | ((w & mask) << sh));
                ref_mem[idx] = merged;
            end

            run_txn(rd, wr, r32, sz, uns, w, lr, lw, o);
            chk($sformatf("rnd%0d_rdata", n), o.rdata, cur_rdata);
            chk($sformatf("rnd%0d_err", n), 32'(o.err), 32'(illegal || rto || wto));
            chk($sformatf("rnd%0d_mem", n), dut_mem[idx], ref_mem[idx]);
            chk($sformatf("rnd%0d_stall", n), o.stall, e_st);
            chk($sformatf("rnd%0d_rd_cycles", n), o.rcnt, e_r);
            chk($sformatf("rnd%0d_wr_cycles", n), o.wcnt, e_w);
            chk($sformatf("rnd%0d_addr", n), 32'(o.addr_ok), 32'h1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
